// File: rtl/key_access_ctrl_if.sv
// Password submission and access-status bundle between a submitter and key_access_ctrl.
interface key_access_ctrl_if;
   logic        pw_valid;
   logic [31:0] pw_data;
   logic        pw_ready;
   logic        access_granted;
   logic        access_denied;
   logic        locked;
   logic [3:0]  fail_count;

   modport master (
      output pw_valid, pw_data,
      input  pw_ready, access_granted, access_denied, locked, fail_count
   );

   modport slave (
      input  pw_valid, pw_data,
      output pw_ready, access_granted, access_denied, locked, fail_count
   );
endinterface

// File: rtl/key_access_ctrl.sv
// Password gatekeeper for the secret-key stage: compares submissions, pulses grant/deny,
// and enforces a timed lockout after MAX_FAILS consecutive failures.
module key_access_ctrl #(
   parameter logic [31:0] PASSWORD       = 32'hCAFEF00D,
   parameter int unsigned MAX_FAILS      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input logic               clk,
   input logic               rst_n,
   key_access_ctrl_if.slave  bus
);

   localparam logic [3:0]       MAX_F    = 4'(MAX_FAILS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CHECK   = 3'd1,
      GRANT   = 3'd2,
      DENY    = 3'd3,
      LOCKOUT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      pw_q, pw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       fail_q, fail_d;
   logic             ready_q, ready_d;
   logic             granted_q, granted_d;
   logic             denied_q, denied_d;
   logic             locked_q, locked_d;

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pw_q      <= '0;
         cnt_q     <= '0;
         fail_q    <= '0;
         ready_q   <= 1'b1;
         granted_q <= 1'b0;
         denied_q  <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pw_q      <= pw_d;
         cnt_q     <= cnt_d;
         fail_q    <= fail_d;
         ready_q   <= ready_d;
         granted_q <= granted_d;
         denied_q  <= denied_d;
         locked_q  <= locked_d;
      end
   end

   // Next-state, capture, failure count and lockout timer
   always_comb begin
      state_d = state_q;
      pw_d    = pw_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      unique case (state_q)
         IDLE: begin
            if (bus.pw_valid && ready_q) begin
               pw_d    = bus.pw_data;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (pw_q == PASSWORD) begin
               state_d = GRANT;
               fail_d  = '0;
            end else begin
               state_d = DENY;
               fail_d  = (fail_q >= MAX_F) ? MAX_F : 4'(fail_q + 4'd1);
            end
         end
         GRANT: state_d = IDLE;
         DENY: begin
            if (fail_q == MAX_F) begin
               state_d = LOCKOUT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               fail_d  = '0;
            end else begin
               cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they register in step with it
   always_comb begin
      ready_d   = 1'b0;
      granted_d = 1'b0;
      denied_d  = 1'b0;
      locked_d  = 1'b0;
      unique case (state_d)
         IDLE:    ready_d   = 1'b1;
         GRANT:   granted_d = 1'b1;
         DENY:    denied_d  = 1'b1;
         LOCKOUT: locked_d  = 1'b1;
         default: ;
      endcase
   end

   assign bus.pw_ready       = ready_q;
   assign bus.access_granted = granted_q;
   assign bus.access_denied  = denied_q;
   assign bus.locked         = locked_q;
   assign bus.fail_count     = fail_q;

endmodule

// File: tb/tb_key_access_ctrl.sv
// Self-checking bench for key_access_ctrl: directed scenarios plus random traffic
// against a timeline-based reference model.
module tb_key_access_ctrl;

   localparam logic [31:0] PW      = 32'hCAFEF00D;
   localparam int          MAXF    = 3;
   localparam int          LOCKCYC = 16;

   logic clk;
   logic rst_n;
   key_access_ctrl_if bus();

   key_access_ctrl #(
      .PASSWORD       (PW),
      .MAX_FAILS      (MAXF),
      .LOCKOUT_CYCLES (LOCKCYC),
      .CNT_W          (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: every accepted submission schedules its visible consequences
   // as absolute sample indices (cycle of pulse, ready return, lockout window).
   typedef struct {int cyc; int val;} sched_t;
   sched_t fq[$];
   int cyc;
   int ready_from, grant_cyc, deny_cyc, lock_lo, lock_hi;
   int fails, exp_fail;
   bit exp_ready;
   int grants_seen;

   task automatic model_reset();
      ready_from = 0;
      grant_cyc  = -1;
      deny_cyc   = -1;
      lock_lo    = 1;
      lock_hi    = 0;
      fails      = 0;
      exp_fail   = 0;
      exp_ready  = 1'b1;
      fq.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".ready"},  32'(bus.pw_ready),       32'd1);
      check({tag, ".grant"},  32'(bus.access_granted), 32'd0);
      check({tag, ".denied"}, 32'(bus.access_denied),  32'd0);
      check({tag, ".locked"}, 32'(bus.locked),         32'd0);
      check({tag, ".fail"},   32'(bus.fail_count),     32'd0);
   endtask

   // Asserted away from the clock edge; outputs must clear without waiting for one.
   task automatic apply_reset(input string tag);
      bus.pw_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals({tag, ".async"});
      @(posedge clk);
      #1;
      check_reset_vals({tag, ".held"});
      #3;
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, advance the model on the edge, compare all outputs.
   task automatic step(input logic v, input logic [31:0] d);
      sched_t s;
      bus.pw_valid = v;
      bus.pw_data  = d;
      @(posedge clk);
      cyc++;
      if (v && exp_ready) begin
         if (d == PW) begin
            grant_cyc  = cyc + 1;
            ready_from = cyc + 2;
            fails      = 0;
            fq.push_back('{cyc + 1, 0});
         end else begin
            fails      = (fails + 1 > MAXF) ? MAXF : fails + 1;
            deny_cyc   = cyc + 1;
            fq.push_back('{cyc + 1, fails});
            if (fails == MAXF) begin
               lock_lo    = cyc + 2;
               lock_hi    = cyc + 1 + LOCKCYC;
               ready_from = cyc + 2 + LOCKCYC;
               fails      = 0;
               fq.push_back('{ready_from, 0});
            end else begin
               ready_from = cyc + 2;
            end
         end
      end
      #1;
      while (fq.size() > 0 && fq[0].cyc <= cyc) begin
         s = fq.pop_front();
         exp_fail = s.val;
      end
      exp_ready = (cyc >= ready_from);
      if (bus.access_granted === 1'b1) grants_seen++;
      check("ready",  32'(bus.pw_ready),       32'(exp_ready));
      check("grant",  32'(bus.access_granted), 32'(cyc == grant_cyc));
      check("denied", 32'(bus.access_denied),  32'(cyc == deny_cyc));
      check("locked", 32'(bus.locked),         32'(cyc >= lock_lo && cyc <= lock_hi));
      check("fail",   32'(bus.fail_count),     32'(exp_fail));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom);
   endtask

   initial begin
      cyc = 0;
      grants_seen = 0;
      bus.pw_valid = 1'b0;
      bus.pw_data  = '0;
      rst_n = 1'b1;
      #2;
      apply_reset("por");
      idle_steps(2);

      // Correct password, single cycle of valid; data changes afterwards
      step(1'b1, PW);
      idle_steps(4);

      // One wrong submission
      step(1'b1, 32'h0000_0000);
      idle_steps(3);
      // Bring count back to zero
      step(1'b1, PW);
      idle_steps(3);

      // Three wrong -> lockout, with correct password offered throughout lockout
      for (int i = 0; i < MAXF; i++) begin
         step(1'b1, 32'h0000_0000);
         idle_steps(2);
      end
      for (int i = 0; i < LOCKCYC + 2; i++) step(1'b1, PW);
      idle_steps(3);

      // Two wrong, one correct, one wrong: count restarts at 1
      step(1'b1, 32'h1234_5678); idle_steps(2);
      step(1'b1, 32'hCAFE_F00C); idle_steps(2);
      step(1'b1, PW);            idle_steps(2);
      step(1'b1, 32'hFFFF_FFFF); idle_steps(3);
      step(1'b1, PW);            idle_steps(3);

      // Valid held with correct password: grant every third cycle
      grants_seen = 0;
      for (int i = 0; i < 15; i++) step(1'b1, PW);
      check("held_valid_grants", 32'(grants_seen), 32'd5);
      idle_steps(3);

      // Reset during lockout (cycle 5 of the window)
      for (int i = 0; i < MAXF; i++) begin
         step(1'b1, 32'hDEAD_BEEF);
         idle_steps(2);
      end
      idle_steps(4);
      check("in_lockout", 32'(bus.locked), 32'd1);
      apply_reset("rst_lock");
      idle_steps(3);
      step(1'b1, PW);
      idle_steps(3);

      // Reset during CHECK of a correct submission: no grant may follow
      step(1'b1, PW);
      apply_reset("rst_check");
      grants_seen = 0;
      idle_steps(4);
      check("aborted_grant", 32'(grants_seen), 32'd0);
      step(1'b1, PW);
      idle_steps(3);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         logic        v;
         logic [31:0] d;
         v = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 3))
            0, 1:    d = PW;
            2:       d = PW ^ (32'd1 << $urandom_range(0, 31));
            default: d = $urandom;
         endcase
         step(v, d);
         if ($urandom_range(0, 199) == 0) apply_reset("rst_rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
